// File: rtl/mdu.sv
// Iterative 32x32 multiply/divide unit: one radix-2 step per clock, 32 steps per op.
// Result words only update on the final step edge; cancel and reset abort cleanly.
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        b_zero;
  logic [31:0] m;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [31:0] a_r;

  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] sum;
  logic [32:0] sh;
  logic [33:0] diff;
  logic [31:0] nx_hi;
  logic [31:0] nx_lo;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[31]) ? -a : a;
  assign mag_b     = (signed_op && b[31]) ? -b : b;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // Multiply: {p_hi,p_lo} holds partial product / remaining multiplier bits.
  // Divide: p_hi is the partial remainder, p_lo shifts dividend out and quotient in.
  always_comb begin
    sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
    sh   = {p_hi, p_lo[31]};
    diff = {1'b0, sh} - {2'b0, m};
    if (is_div) begin
      if (!diff[33]) begin
        nx_hi = diff[31:0];
        nx_lo = {p_lo[30:0], 1'b1};
      end else begin
        nx_hi = sh[31:0];
        nx_lo = {p_lo[30:0], 1'b0};
      end
    end else begin
      nx_hi = sum[32:1];
      nx_lo = {sum[0], p_lo[31:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_zero) begin
      res_hi = a_r;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -nx_hi : nx_hi;
      res_lo = neg_q ? -nx_lo : nx_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      m      <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      a_r    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !cancel) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= signed_op & (a[31] ^ b[31]);
            neg_r  <= signed_op & a[31];
            b_zero <= (b == 32'd0);
            m      <= op[1] ? mag_b : mag_a;
            p_hi   <= '0;
            p_lo   <= op[1] ? mag_a : mag_b;
            a_r    <= a;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            p_hi <= nx_hi;
            p_lo <= nx_lo;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              hi    <= res_hi;
              lo    <= res_lo;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
